inst_prefetch_queue: RTL and testbench

//  Fetch stage placed in front of the instruction decoder. Issues sequential 32-bit instruction

---
 rtl/inst_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch requests, in-order response FIFO, redirect flush.
// Optional zero-latency response bypass when PREFETCH_BYPASS_EN is defined.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [63:0]      mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_out,
    output logic [63:0]      inst_pc,
    output logic [CNT_W-1:0] queue_count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic             active_q;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [63:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_inst_q [DEPTH];
    logic [63:0]      fifo_pc_q   [DEPTH];
    logic [31:0]      hold_inst_q;
    logic [63:0]      hold_pc_q;

    logic [CNT_W:0]   occupancy;
    logic [63:0]      redirect_aligned;
    logic             req_fire, rsp_seen, fifo_empty, fifo_full;
    logic             bypass_hit, bypass_take, deq, enq;

    // Requests are throttled so every in-flight response is guaranteed a FIFO slot.
    assign occupancy        = {1'b0, count_q} + {1'b0, outstanding_q};
    assign mem_req_valid    = active_q && (occupancy < DEPTH_W);
    assign mem_req_addr     = fetch_pc_q;
    assign req_fire         = mem_req_valid && mem_req_ready;
    assign rsp_seen         = mem_rsp_valid && (outstanding_q != '0);
    assign fifo_empty       = (count_q == '0);
    assign fifo_full        = (count_q == DEPTH_C);
    assign redirect_aligned = redirect_pc & ~64'h3;
    assign queue_count      = count_q;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = fifo_empty && (drop_q == '0) && rsp_seen && !redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign inst_valid  = !fifo_empty || bypass_hit;
    assign inst_out    = !fifo_empty ? fifo_inst_q[rd_ptr_q] : (bypass_hit ? mem_rsp_data : hold_inst_q);
    assign inst_pc     = !fifo_empty ? fifo_pc_q[rd_ptr_q]   : (bypass_hit ? rsp_pc_q     : hold_pc_q);
    assign bypass_take = bypass_hit && inst_ready;
    assign deq         = !fifo_empty && inst_ready;
    assign enq         = rsp_seen && (drop_q == '0) && !redirect_valid && !bypass_take && !fifo_full;

    // Redirect wins over everything except the head handshake happening in the same cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_seen);
        drop_d        = drop_q;
        count_d       = count_q + CNT_W'(enq) - CNT_W'(deq);
        rd_ptr_d      = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d      = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
        end
        if (enq || bypass_take) begin
            rsp_pc_d = rsp_pc_q + 64'd4;
        end
        if (rsp_seen && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            drop_d     = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            hold_inst_q   <= '0;
            hold_pc_q     <= '0;
        end else begin
            active_q      <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            hold_inst_q   <= inst_out;
            hold_pc_q     <= inst_pc;
        end
    end

    // Storage entries carry the PC alongside the word so the decoder never recomputes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (enq) begin
            fifo_inst_q[wr_ptr_q] <= mem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue with an in-order 1-cycle memory model.
// Expected values adapt to whether PREFETCH_BYPASS_EN is defined.
module tb_inst_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [63:0] LAT  = BYP ? 64'd4 : 64'd8;
    localparam logic [63:0] TOPW = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic [2:0]  queue_count;

    int          total = 0;
    int          bad = 0;
    int          fireCount;
    bit          rspEnable;
    logic [63:0] pendQ[$];
    logic [63:0] pop;

    always #5 clk = ~clk;

    inst_prefetch_queue dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .queue_count(queue_count)
    );

    function automatic logic [31:0] wordOf(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record the accepted request, then present the oldest pending response.
    task automatic step();
        #1;
        if (mem_req_valid && mem_req_ready) begin
            fireCount++;
            pendQ.push_back(mem_req_addr);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (rspEnable && pendQ.size() > 0) begin
            pop           = pendQ.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = wordOf(pop);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 12 && !inst_valid; i++) step();
        check(tag, inst_valid, 1);
    endtask

    task automatic doReset(input bit checkIdle);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b1;
        rspEnable      = 1'b1;
        pendQ.delete();
        repeat (2) @(posedge clk);
        #1;
        if (checkIdle) begin
            check("rst req_valid", mem_req_valid, 0);
            check("rst inst_valid", inst_valid, 0);
            check("rst inst_out", inst_out, 0);
            check("rst inst_pc", inst_pc, 0);
            check("rst count", queue_count, 0);
        end
        reset     = 1'b1;
        fireCount = 0;
        step();
    endtask

    initial begin
        // Sequential fetch with an always-ready decoder.
        doReset(1'b1);
        check("t1 first addr", mem_req_addr, 64'h2000);
        check("t1 first valid", mem_req_valid, 1);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("t1 addr", mem_req_addr, 64'h2008 + 64'(4 * i));
            check("t1 inst_pc", inst_pc, 64'h2008 + 64'(4 * i) - LAT);
            check("t1 inst_out", inst_out, wordOf(64'h2008 + 64'(4 * i) - LAT));
            check("t1 count", queue_count, BYP ? 0 : 1);
            step();
        end

        // Back-pressure fills the queue; one dequeue frees exactly one request.
        doReset(1'b0);
        inst_ready = 1'b0;
        repeat (10) step();
        check("t2 fires", fireCount, 4);
        check("t2 count full", queue_count, 4);
        check("t2 req_valid", mem_req_valid, 0);
        check("t2 head pc", inst_pc, 64'h2000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        repeat (6) step();
        check("t2 fires after", fireCount, 5);
        check("t2 count refill", queue_count, 4);
        check("t2 head pc after", inst_pc, 64'h2004);

        // Redirect with two requests still in flight.
        doReset(1'b0);
        rspEnable = 1'b0;
        step();
        step();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3002;
        check("t3 count pre", queue_count, 0);
        step();
        check("t3 new addr", mem_req_addr, 64'h3000);
        mem_req_ready = 1'b1;
        rspEnable     = 1'b1;
        step();
        check("t3 stale0 hidden", inst_valid, 0);
        step();
        check("t3 stale1 hidden", inst_valid, 0);
        waitValid("t3 valid timeout");
        check("t3 first pc", inst_pc, 64'h3000);
        check("t3 first word", inst_out, wordOf(64'h3000));

        // Redirect coinciding with a response and a head handshake.
        doReset(1'b0);
        inst_ready = 1'b0;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        inst_ready     = 1'b1;
        #1;
        check("t4 head valid", inst_valid, 1);
        check("t4 head pc", inst_pc, 64'h2000);
        check("t4 count pre", queue_count, 2);
        step();
        check("t4 count flushed", queue_count, 0);
        check("t4 valid flushed", inst_valid, 0);
        check("t4 new addr", mem_req_addr, 64'h4000);
        waitValid("t4 valid timeout");
        check("t4 first pc", inst_pc, 64'h4000);
        check("t4 first word", inst_out, wordOf(64'h4000));

        // Address wrap at the top of the 64-bit space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("t5 top addr", mem_req_addr, TOPW);
        for (int i = 0; i < 12 && mem_req_addr == TOPW; i++) step();
        check("t5 wrapped addr", mem_req_addr, 64'h0);
        waitValid("t5 valid timeout");
        check("t5 top pc", inst_pc, TOPW);
        check("t5 top word", inst_out, wordOf(TOPW));
        step();
        waitValid("t5 valid2 timeout");
        check("t5 wrapped pc", inst_pc, 64'h0);

        // Response into an empty queue: same-cycle with bypass, next cycle otherwise.
        doReset(1'b0);
        rspEnable = 1'b0;
        step();
        mem_req_ready = 1'b0;
        pop           = pendQ.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        inst_ready    = 1'b1;
        #1;
        check("t6 same valid", inst_valid, BYP ? 1 : 0);
        check("t6 same out", inst_out, BYP ? 32'hDEAD_BEEF : 32'h0);
        check("t6 same pc", inst_pc, BYP ? 64'h2000 : 64'h0);
        check("t6 same count", queue_count, 0);
        step();
        check("t6 next valid", inst_valid, BYP ? 0 : 1);
        check("t6 next count", queue_count, BYP ? 0 : 1);
        check("t6 next out", inst_out, 32'hDEAD_BEEF);
        check("t6 next pc", inst_pc, 64'h2000);
        step();
        check("t6 drained count", queue_count, 0);
        check("t6 drained valid", inst_valid, 0);
        check("t6 hold out", inst_out, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
